// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and 8N1 frame constants for the uart
//
// Purpose: one home for the TX/RX state encoding and the frame shape so the
//          top and any future helpers agree on them.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter producing a one-cycle tick
//
// Purpose: counts CLKS_PER_BIT cycles per bit. A restart loads either a full
//          period or a half period (used by RX to land on the start-bit
//          centre); after each tick the counter reloads a full period.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   i_restart  in   reload the counter this cycle
//   i_half     in   with i_restart, load a half period instead of a full one
//   o_tick     out  one-cycle pulse as the current period expires
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  input  logic i_half,
  output logic o_tick
);

  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= i_half ? HALF_LOAD : FULL_LOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= FULL_LOAD;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // A restart wins over a stale expiry so the new period starts cleanly.
  assign o_tick = (r_cnt == '0) && !i_restart;

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 uart with independent TX and RX engines
//
// Purpose: serialises tx_data on tx and deserialises rx into rx_data.
// Config:  define UART_RX_MAJORITY_EN to take each RX sample as the 2-of-3
//          majority around the bit centre (decision one cycle after centre);
//          otherwise the single synchronised value at the centre is used.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_req    in   single-cycle transmit request (accepted in IDLE only)
//   tx_data   in   byte to send, sampled with tx_req
//   rx        in   asynchronous serial input, idle high
//   tx        out  registered serial output, idle high
//   rx_data   out  last correctly framed received byte
//   tx_ready  out  one-cycle pulse when a frame has been sent
//   rx_ready  out  one-cycle pulse when rx_data is updated
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  output logic       rx_ready
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_t          r_tx_state, w_tx_state_nxt;
  logic [7:0]           r_tx_shift, w_tx_shift_nxt;
  logic [BIT_CNT_W-1:0] r_tx_bit,   w_tx_bit_nxt;
  logic                 r_tx,       w_tx_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic                 w_tx_restart, w_tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_restart (w_tx_restart),
    .i_half    (1'b0),
    .o_tick    (w_tx_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_ready <= w_tx_ready_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_nxt       = r_tx;
    w_tx_ready_nxt = 1'b0;
    w_tx_restart   = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        if (tx_req) begin
          w_tx_state_nxt = ST_START;
          w_tx_shift_nxt = tx_data;
          w_tx_nxt       = 1'b0;
          w_tx_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = ST_DATA;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = r_tx_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tx_tick) begin
          if (r_tx_bit == LAST_BIT) begin
            w_tx_state_nxt = ST_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + BIT_CNT_W'(1);
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_tx_nxt       = r_tx_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = ST_IDLE;
          w_tx_ready_nxt = 1'b1;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;

  // ---------------- receiver ----------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_rx_tick, w_rx_restart, w_rx_sample_en, w_rx_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // One cycle after the centre tick: r_rx_prev2 holds centre-1, r_rx_prev
  // holds centre and r_rx_sync holds centre+1.
  logic r_rx_prev2, r_rx_tick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_prev2  <= 1'b1;
      r_rx_tick_d <= 1'b0;
    end else begin
      r_rx_prev2  <= r_rx_prev;
      r_rx_tick_d <= w_rx_tick;
    end
  end

  assign w_rx_sample_en = r_rx_tick_d;
  assign w_rx_bit = (r_rx_sync & r_rx_prev) | (r_rx_sync & r_rx_prev2) |
                    (r_rx_prev & r_rx_prev2);
`else
  assign w_rx_sample_en = w_rx_tick;
  assign w_rx_bit       = r_rx_sync;
`endif

  uart_state_t          r_rx_state, w_rx_state_nxt;
  logic [7:0]           r_rx_shift, w_rx_shift_nxt;
  logic [BIT_CNT_W-1:0] r_rx_bit,   w_rx_bit_nxt;
  logic [7:0]           r_rx_data,  w_rx_data_nxt;
  logic                 r_rx_ready, w_rx_ready_nxt;
  logic                 r_rx_ferr,  w_rx_ferr_nxt;

  // Only the start detection restarts the timer, and always with a half
  // period; later samples follow from the timer's own full-period reload.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_restart (w_rx_restart),
    .i_half    (1'b1),
    .o_tick    (w_rx_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
      r_rx_data  <= '0;
      r_rx_ready <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_rx_ferr  <= w_rx_ferr_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_data_nxt  = r_rx_data;
    w_rx_ready_nxt = 1'b0;
    w_rx_ferr_nxt  = r_rx_ferr;
    w_rx_restart   = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = ST_START;
          w_rx_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_rx_sample_en) begin
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = w_rx_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_sample_en) begin
          w_rx_shift_nxt = {w_rx_bit, r_rx_shift[7:1]};
          if (r_rx_bit == LAST_BIT) begin
            w_rx_state_nxt = ST_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + BIT_CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        // After a framing error, stay here until the line returns high so a
        // held-low line is not mistaken for a new start bit.
        if (r_rx_ferr) begin
          if (r_rx_sync) begin
            w_rx_state_nxt = ST_IDLE;
            w_rx_ferr_nxt  = 1'b0;
          end
        end else if (w_rx_sample_en) begin
          if (w_rx_bit) begin
            w_rx_data_nxt  = r_rx_shift;
            w_rx_ready_nxt = 1'b1;
            w_rx_state_nxt = ST_IDLE;
          end else begin
            w_rx_ferr_nxt = 1'b1;
          end
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  assign rx_data  = r_rx_data;
  assign rx_ready = r_rx_ready;

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed self-checking bench for the uart at CLKS_PER_BIT=16
module tb_uart;

  localparam int N = 16;

  logic       clk;
  logic       reset_n;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       rx_ready;
  logic       loop_en;
  logic       rx_drv;
  logic       w_rx;

  int n_vectors;
  int n_miscompares;
  int rx_cnt;
  int tx_ready_cnt;
  logic [7:0] rx_q[$];

  assign w_rx = loop_en ? tx : rx_drv;

  uart #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .rx       (w_rx),
    .tx       (tx),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_ready) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_ready) tx_ready_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Checks the line at each bit centre and the
  // tx_ready position; optionally pokes a tx_req mid-frame.
  task automatic tx_frame(input logic [7:0] d, input bit busy_req, input string tag);
    int k_ready;
    k_ready = -1;
    tx_data = d;
    tx_req  = 1'b1;
    for (int k = 0; k < 200 && k_ready < 0; k++) begin
      @(negedge clk);
      tx_req = 1'b0;
      if (busy_req && k == 50) begin
        tx_req  = 1'b1;
        tx_data = 8'h00;
      end
      if (k == 0)  check({tag, " start edge"}, tx, 1'b0);
      if (k == 8)  check({tag, " start centre"}, tx, 1'b0);
      if (k >= 24 && k < 152 && (k - 24) % N == 0)
        check($sformatf("%s bit%0d", tag, (k - 24) / N), tx, d[(k - 24) / N]);
      if (k == 152) check({tag, " stop"}, tx, 1'b1);
      if (tx_ready) k_ready = k;
    end
    check({tag, " tx_ready cycle"}, k_ready, 160);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (N) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] b2b[4];
    int base, last_t, n_ready, idx;
    bit tx_stayed_high;

    n_vectors = 0; n_miscompares = 0; rx_cnt = 0; tx_ready_cnt = 0;
    reset_n = 1'b0; tx_req = 1'b0; tx_data = 8'h00; loop_en = 1'b1; rx_drv = 1'b1;
    b2b[0] = 8'hDE; b2b[1] = 8'hAD; b2b[2] = 8'hBE; b2b[3] = 8'hEF;

    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset tx_ready", tx_ready, 1'b0);
    check("reset rx_ready", rx_ready, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of a single DE frame
    base = rx_cnt;
    tx_frame(8'hDE, 1'b0, "loop DE");
    repeat (5) @(negedge clk);
    check("loop rx count", rx_cnt - base, 1);
    check("loop rx_data", rx_data, 8'hDE);

    // Back-to-back frames, each request on the tx_ready pulse
    repeat (20) @(negedge clk);
    rx_q.delete();
    base = rx_cnt;
    last_t = -1; n_ready = 0; idx = 1;
    tx_data = b2b[0];
    tx_req  = 1'b1;
    for (int t = 0; t < 1000 && n_ready < 4; t++) begin
      @(negedge clk);
      tx_req = 1'b0;
      if (tx_ready) begin
        if (last_t >= 0) check($sformatf("b2b interval %0d", n_ready), t - last_t, 161);
        last_t = t;
        n_ready++;
        if (idx < 4) begin
          tx_data = b2b[idx];
          tx_req  = 1'b1;
          idx++;
        end
      end
    end
    check("b2b tx_ready count", n_ready, 4);
    repeat (10) @(negedge clk);
    check("b2b rx count", rx_cnt - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b2b byte%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, b2b[i]);

    // Short low glitch on rx must be rejected as a false start
    loop_en = 1'b0;
    repeat (5) @(negedge clk);
    base = rx_cnt;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch rx count", rx_cnt - base, 0);
    check("glitch rx_data", rx_data, 8'hEF);

    // Framing error on 55, then a good AA frame
    base = rx_cnt;
    drive_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr rx count", rx_cnt - base, 0);
    check("ferr rx_data", rx_data, 8'hEF);
    drive_frame(8'hAA, 1'b1);
    repeat (10) @(negedge clk);
    check("after ferr rx count", rx_cnt - base, 1);
    check("after ferr rx_data", rx_data, 8'hAA);
    loop_en = 1'b1;
    repeat (10) @(negedge clk);

    // tx_req mid-frame is ignored; the line carries FF
    base = rx_cnt;
    tx_frame(8'hFF, 1'b1, "busy FF");
    repeat (5) @(negedge clk);
    check("busy rx count", rx_cnt - base, 1);
    check("busy rx_data", rx_data, 8'hFF);
    repeat (30) @(negedge clk);
    check("busy no extra frame", tx, 1'b1);

    // Reset mid-frame of 00 aborts at once with no pulses afterwards
    tx_data = 8'h00;
    tx_req  = 1'b1;
    repeat (70) begin
      @(negedge clk);
      tx_req = 1'b0;
    end
    check("pre-reset tx low", tx, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid reset tx", tx, 1'b1);
    check("mid reset tx_ready", tx_ready, 1'b0);
    check("mid reset rx_data", rx_data, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base = rx_cnt;
    idx  = tx_ready_cnt;
    tx_stayed_high = 1'b1;
    repeat (250) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_stayed_high = 1'b0;
    end
    check("post reset tx idle", tx_stayed_high, 1'b1);
    check("post reset tx_ready", tx_ready_cnt - idx, 0);
    check("post reset rx_ready", rx_cnt - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
